// File: rtl/decode_issue_buffer.sv
// decode_issue_buffer: decodes fetched instructions, resolves operands and queues them for issue.
// Ports: clk/rst (async, active-low), rdy (global enable), clr (flush); in_* fetch side;
// rs*_reg_pos/reg_* register-file lookup; rob_* ROB lookup and allocation; cdb_* result snoop;
// out_* head entry toward RS/LSB; count = buffered entries.
// Optional: ISSUE_BUF_BYPASS_EN lets an instruction entering an empty buffer appear on out_* in the same cycle.
module decode_issue_buffer #(
    parameter int DEPTH    = 4,
    parameter int CDB_NUM  = 2,
    parameter int TAG_W    = 5,
    parameter int OPENUM_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [OPENUM_W-1:0]      in_openum,
    input  logic [31:0]              in_pc,
    input  logic                     in_pred_jump,
    input  logic                     in_rs_en,
    input  logic                     in_lsb_en,
    output logic [4:0]               rs1_reg_pos,
    output logic [4:0]               rs2_reg_pos,
    input  logic [31:0]              reg_rs1_val,
    input  logic [31:0]              reg_rs2_val,
    input  logic [TAG_W-1:0]         reg_rs1_tag,
    input  logic [TAG_W-1:0]         reg_rs2_tag,
    output logic [TAG_W-1:0]         rob_rs1_tag,
    output logic [TAG_W-1:0]         rob_rs2_tag,
    input  logic                     rob_rs1_ready,
    input  logic                     rob_rs2_ready,
    input  logic [31:0]              rob_rs1_val,
    input  logic [31:0]              rob_rs2_val,
    input  logic [TAG_W-1:0]         rob_next_pos,
    output logic                     rob_alloc,
    input  logic [CDB_NUM-1:0]       cdb_valid,
    input  logic [CDB_NUM*TAG_W-1:0] cdb_tag,
    input  logic [CDB_NUM*32-1:0]    cdb_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPENUM_W-1:0]      out_openum,
    output logic [4:0]               out_rd,
    output logic [31:0]              out_rs1_val,
    output logic [TAG_W-1:0]         out_rs1_tag,
    output logic [31:0]              out_rs2_val,
    output logic [TAG_W-1:0]         out_rs2_tag,
    output logic [31:0]              out_imm,
    output logic [31:0]              out_pc,
    output logic                     out_pred_jump,
    output logic                     out_store,
    output logic [TAG_W-1:0]         out_rob_pos,
    output logic                     out_rs_en,
    output logic                     out_lsb_en,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [OPENUM_W-1:0] op;
        logic [4:0]          rd;
        logic [31:0]         v1;
        logic [TAG_W-1:0]    t1;
        logic [31:0]         v2;
        logic [TAG_W-1:0]    t2;
        logic [31:0]         imm;
        logic [31:0]         pc;
        logic                pj;
        logic                st;
        logic [TAG_W-1:0]    rob;
        logic                rs;
        logic                lsb;
    } ent_t;

    // Returns {tag, val}; a pending tag picks up the lowest-index matching broadcast.
    function automatic logic [TAG_W+31:0] snoop(input logic [TAG_W-1:0] t, input logic [31:0] v);
        snoop = {t, v};
        for (int k = CDB_NUM - 1; k >= 0; k--)
            if (t != '0 && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == t)
                snoop = {{TAG_W{1'b0}}, cdb_val[k*32 +: 32]};
    endfunction

    function automatic logic [TAG_W+31:0] resolve(input logic [TAG_W-1:0] t, input logic [31:0] rv,
                                                  input logic rr, input logic [31:0] bv);
        return (t == '0) ? {t, rv} : rr ? {{TAG_W{1'b0}}, bv} : snoop(t, 32'd0);
    endfunction

    ent_t             mem [DEPTH];
    ent_t             snp [DEPTH];
    ent_t             dec;
    ent_t             head_e;
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             enq;
    logic             deq;
    logic             byp;
    logic             wr;
    logic             pop;
    logic [6:0]       opc;
    logic             is_i;
    logic             is_s;
    logic             is_b;
    logic             is_j;
    logic             is_u;

    assign rs1_reg_pos = in_inst[19:15];
    assign rs2_reg_pos = in_inst[24:20];
    assign rob_rs1_tag = reg_rs1_tag;
    assign rob_rs2_tag = reg_rs2_tag;

    assign opc  = in_inst[6:0];
    assign is_i = opc == 7'b0000011 || opc == 7'b0010011 || opc == 7'b1100111;
    assign is_s = opc == 7'b0100011;
    assign is_b = opc == 7'b1100011;
    assign is_j = opc == 7'b1101111;
    assign is_u = opc == 7'b0110111 || opc == 7'b0010111;

    always_comb begin
        dec = '0;
        dec.op = in_openum;
        dec.rd = (is_s || is_b) ? 5'd0 : in_inst[11:7];
        {dec.t1, dec.v1} = (is_j || is_u) ? '0 : resolve(reg_rs1_tag, reg_rs1_val, rob_rs1_ready, rob_rs1_val);
        {dec.t2, dec.v2} = (is_i || is_j || is_u) ? '0 : resolve(reg_rs2_tag, reg_rs2_val, rob_rs2_ready, rob_rs2_val);
        dec.imm = is_i ? {{20{in_inst[31]}}, in_inst[31:20]} :
                  is_s ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
                  is_b ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
                  is_j ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
                  is_u ? {in_inst[31:12], 12'b0} : 32'd0;
        dec.pc = in_pc;
        dec.pj = in_pred_jump;
        dec.st = is_s;
        dec.rob = rob_next_pos;
        dec.rs = in_rs_en;
        dec.lsb = in_lsb_en;
    end

    // Snooped view of every entry: feeds both the storage update and the head forwarding path.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snp[i] = mem[i];
            {snp[i].t1, snp[i].v1} = snoop(mem[i].t1, mem[i].v1);
            {snp[i].t2, snp[i].v2} = snoop(mem[i].t2, mem[i].v2);
        end
    end

    assign in_ready  = rst && rdy && !clr && (count < CW'(DEPTH));
    assign enq       = in_valid && in_ready;
    assign rob_alloc = enq;
`ifdef ISSUE_BUF_BYPASS_EN
    assign byp = enq && count == '0;
`else
    assign byp = 1'b0;
`endif
    assign out_valid = rdy && !clr && (vld[head] || byp);
    assign deq       = out_valid && out_ready;
    // A bypassed instruction consumed in the same cycle never occupies a slot.
    assign wr        = enq && !(byp && deq);
    assign pop       = deq && !byp;
    assign head_e    = byp ? dec : snp[head];

    assign {out_openum, out_rd, out_rs1_val, out_rs1_tag, out_rs2_val, out_rs2_tag, out_imm, out_pc,
            out_pred_jump, out_store, out_rob_pos, out_rs_en, out_lsb_en} = out_valid ? head_e : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (rdy) begin
            if (clr) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                vld   <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= snp[i];
                if (wr) begin
                    mem[tail] <= dec;
                    vld[tail] <= 1'b1;
                    tail      <= tail + PW'(1);
                end
                if (pop) begin
                    vld[head] <= 1'b0;
                    head      <= head + PW'(1);
                end
                count <= count + CW'(wr) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_decode_issue_buffer.sv
// tb_decode_issue_buffer: scoreboard bench for decode_issue_buffer (default build, no bypass).
module tb_decode_issue_buffer;
    logic        clk = 0, rst = 0, rdy = 1, clr = 0;
    logic        in_valid = 0, in_ready;
    logic [31:0] in_inst = 0, in_pc = 0;
    logic [5:0]  in_openum = 0;
    logic        in_pred_jump = 0, in_rs_en = 0, in_lsb_en = 0;
    logic [4:0]  rs1_reg_pos, rs2_reg_pos;
    logic [31:0] reg_rs1_val = 0, reg_rs2_val = 0;
    logic [4:0]  reg_rs1_tag = 0, reg_rs2_tag = 0;
    logic [4:0]  rob_rs1_tag, rob_rs2_tag;
    logic        rob_rs1_ready = 0, rob_rs2_ready = 0;
    logic [31:0] rob_rs1_val = 0, rob_rs2_val = 0;
    logic [4:0]  rob_next_pos = 0;
    logic        rob_alloc;
    logic [1:0]  cdb_valid = 0;
    logic [9:0]  cdb_tag = 0;
    logic [63:0] cdb_val = 0;
    logic        out_valid, out_ready = 0;
    logic [5:0]  out_openum;
    logic [4:0]  out_rd, out_rs1_tag, out_rs2_tag, out_rob_pos;
    logic [31:0] out_rs1_val, out_rs2_val, out_imm, out_pc;
    logic        out_pred_jump, out_store, out_rs_en, out_lsb_en;
    logic [2:0]  count;

    always #5 clk = ~clk;

    decode_issue_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_openum(in_openum),
        .in_pc(in_pc), .in_pred_jump(in_pred_jump), .in_rs_en(in_rs_en), .in_lsb_en(in_lsb_en),
        .rs1_reg_pos(rs1_reg_pos), .rs2_reg_pos(rs2_reg_pos),
        .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
        .reg_rs1_tag(reg_rs1_tag), .reg_rs2_tag(reg_rs2_tag),
        .rob_rs1_tag(rob_rs1_tag), .rob_rs2_tag(rob_rs2_tag),
        .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
        .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val),
        .rob_next_pos(rob_next_pos), .rob_alloc(rob_alloc),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_openum(out_openum), .out_rd(out_rd),
        .out_rs1_val(out_rs1_val), .out_rs1_tag(out_rs1_tag),
        .out_rs2_val(out_rs2_val), .out_rs2_tag(out_rs2_tag),
        .out_imm(out_imm), .out_pc(out_pc), .out_pred_jump(out_pred_jump), .out_store(out_store),
        .out_rob_pos(out_rob_pos), .out_rs_en(out_rs_en), .out_lsb_en(out_lsb_en), .count(count)
    );

    typedef struct {
        logic [31:0] imm, v1, v2, pc;
        logic [4:0]  rd, t1, t2, rob;
        logic [5:0]  op;
        logic        st, pj, rs, lsb;
    } exp_t;

    exp_t       sb[$];
    int         total = 0, bad = 0;
    logic [4:0] rp = 0;
    logic [31:0] fill [4] = '{32'hFE532E23, 32'hFE000EE3, 32'h8000006F, 32'hABCDE0B7};
    logic [6:0]  ops [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t fix(input exp_t e);
        exp_t r = e;
        for (int k = 0; k < 2; k++) begin
            if (r.t1 != 0 && cdb_valid[k] && cdb_tag[k*5 +: 5] == r.t1) begin r.t1 = 0; r.v1 = cdb_val[k*32 +: 32]; end
            if (r.t2 != 0 && cdb_valid[k] && cdb_tag[k*5 +: 5] == r.t2) begin r.t2 = 0; r.v2 = cdb_val[k*32 +: 32]; end
        end
        return r;
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic [31:0] i = in_inst;
        e.op = in_openum; e.pc = in_pc; e.rob = rob_next_pos; e.st = 0; e.rd = i[11:7];
        e.pj = in_pred_jump; e.rs = in_rs_en; e.lsb = in_lsb_en;
        e.t1 = reg_rs1_tag; e.v1 = 0; e.t2 = reg_rs2_tag; e.v2 = 0;
        if (e.t1 == 0) e.v1 = reg_rs1_val; else if (rob_rs1_ready) begin e.t1 = 0; e.v1 = rob_rs1_val; end
        if (e.t2 == 0) e.v2 = reg_rs2_val; else if (rob_rs2_ready) begin e.t2 = 0; e.v2 = rob_rs2_val; end
        e = fix(e);
        case (i[6:0])
            7'h03, 7'h13, 7'h67: begin e.imm = {{20{i[31]}}, i[31:20]}; e.t2 = 0; e.v2 = 0; end
            7'h23: begin e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; e.rd = 0; e.st = 1; end
            7'h63: begin e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; e.rd = 0; end
            7'h6F: begin e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; e.t1 = 0; e.v1 = 0; e.t2 = 0; e.v2 = 0; end
            7'h37, 7'h17: begin e.imm = {i[31:12], 12'b0}; e.t1 = 0; e.v1 = 0; e.t2 = 0; e.v2 = 0; end
            default: e.imm = 0;
        endcase
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [4:0] t1, input logic [4:0] t2,
                         input logic r1, input logic r2);
        in_valid = v; in_inst = inst; reg_rs1_tag = t1; reg_rs2_tag = t2;
        rob_rs1_ready = r1; rob_rs2_ready = r2;
        reg_rs1_val = $urandom; reg_rs2_val = $urandom; rob_rs1_val = $urandom; rob_rs2_val = $urandom;
        in_pc = $urandom; in_openum = 6'($urandom); in_pred_jump = 1'($urandom);
        in_rs_en = 1'($urandom); in_lsb_en = 1'($urandom);
        rob_next_pos = rp; rp = rp + 5'd1;
    endtask

    task automatic step();
        bit ov, ir;
        exp_t e;
        #1;
        ov = rdy && !clr && sb.size() > 0;
        ir = rst && rdy && !clr && sb.size() < 4;
        chk("count", count, sb.size());
        chk("out_valid", out_valid, ov);
        chk("in_ready", in_ready, ir);
        chk("rob_alloc", rob_alloc, in_valid && ir);
        chk("reg_pos", {rs1_reg_pos, rs2_reg_pos}, {in_inst[19:15], in_inst[24:20]});
        chk("rob_tag", {rob_rs1_tag, rob_rs2_tag}, {reg_rs1_tag, reg_rs2_tag});
        if (!ov) chk("idle_payload", {out_imm, out_rs1_val}, 64'd0);
        if (rdy && clr) sb.delete();
        else if (rdy) begin
            foreach (sb[j]) sb[j] = fix(sb[j]);
            if (ov && out_ready) begin
                e = sb.pop_front();
                chk("imm", out_imm, e.imm);
                chk("rd", out_rd, e.rd);
                chk("rs1_val", out_rs1_val, e.v1);
                chk("rs1_tag", out_rs1_tag, e.t1);
                chk("rs2_val", out_rs2_val, e.v2);
                chk("rs2_tag", out_rs2_tag, e.t2);
                chk("rob_pos", out_rob_pos, e.rob);
                chk("pc", out_pc, e.pc);
                chk("openum", out_openum, e.op);
                chk("flags", {out_store, out_pred_jump, out_rs_en, out_lsb_en}, {e.st, e.pj, e.rs, e.lsb});
            end
            if (in_valid && ir) sb.push_back(model());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 32'd0, 0, 0, 0, 0);
    endtask

    initial begin
        in_valid = 1;
        @(negedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rob_alloc", rob_alloc, 0);
        @(negedge clk);
        rst = 1;
        // ADDI x1,x0,5
        out_ready = 1;
        drive(1, 32'h00500093, 0, 0, 0, 0); step();
        idle(); step(); step();
        // ADD with rs1 pending on tag 3, resolved two cycles later on channel 1
        out_ready = 0;
        drive(1, 32'h002081B3, 3, 0, 0, 0); step();
        idle(); step();
        cdb_valid = 2'b10; cdb_tag = {5'd3, 5'd0}; cdb_val = {32'h77, 32'h0}; step();
        cdb_valid = 0;
        out_ready = 1; step(); step();
        // fill to DEPTH, then deq-only at full, then enq+deq at count 3
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin drive(1, fill[i], 5'(i + 1), 5'd0, 1'b0, 1'b1); step(); end
        drive(1, 32'h00B50533, 0, 0, 0, 0); step();
        out_ready = 1;
        drive(1, 32'h00B50533, 0, 0, 0, 0); step();
        drive(1, 32'h00C58633, 0, 2, 0, 1); step();
        idle(); repeat (4) step();
        // head rs2 pending on tag 7 resolved in its dequeue cycle; both channels match, channel 0 wins
        out_ready = 0;
        drive(1, 32'h00B50533, 0, 7, 0, 0); step();
        idle();
        cdb_valid = 2'b11; cdb_tag = {5'd7, 5'd7}; cdb_val = {32'h1111, 32'hABCD};
        out_ready = 1; step();
        cdb_valid = 0; step();
        // flush with three entries
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin drive(1, 32'h00A00113, 0, 0, 0, 0); step(); end
        idle(); clr = 1; step();
        clr = 0; step();
        // rdy low holds state and ignores broadcasts
        drive(1, 32'h002081B3, 9, 0, 0, 0); step();
        drive(1, 32'h00500093, 0, 0, 0, 0);
        rdy = 0; out_ready = 1; cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd9}; cdb_val = {32'h0, 32'h5A5A};
        step();
        rdy = 1; cdb_valid = 0; idle(); step(); step();
        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            drive(1'($urandom), $urandom & 32'hFFFFFF80 | 32'(ops[$urandom_range(0, 8)]),
                  5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)), 1'($urandom), 1'($urandom));
            out_ready = 1'($urandom);
            cdb_valid = 2'($urandom);
            cdb_tag = {5'($urandom_range(1, 6)), 5'($urandom_range(1, 6))};
            cdb_val = {$urandom, $urandom};
            clr = $urandom_range(0, 15) == 0;
            rdy = $urandom_range(0, 7) != 0;
            step();
        end
        clr = 0; rdy = 1; cdb_valid = 0; out_ready = 0;
        idle(); step();
        // asynchronous reset in the middle of an enqueue
        for (int i = 0; i < 2; i++) begin drive(1, 32'h00700193, 0, 0, 0, 0); step(); end
        drive(1, 32'h00700193, 0, 0, 0, 0);
        #2 rst = 0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_rob_alloc", rob_alloc, 0);
        sb.delete();
        @(negedge clk);
        rst = 1;
        drive(1, 32'h00500093, 0, 0, 0, 0); step();
        out_ready = 1; idle(); step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
